// File: rtl/div_seq_pkg.sv
// Shared encodings for the iterative RV32M divider: op codes, FSM states and a negate helper.
package div_seq_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

endpackage

// File: rtl/div_seq_comp.sv
// 32-bit subtract-based comparator: diff = data1 - data2, cout = (data1 >= data2) unsigned.
module comp (
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [31:0] diff,
   output logic        cout
);

   assign {cout, diff} = {1'b0, data1} + {1'b0, ~data2} + 33'd1;

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// operand capture, sign fix-up, special cases and valid/ready handshake.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   state_e           state;
   logic [1:0]       op_q;
   logic             neg_q, neg_r;
   logic [XLEN-1:0]  dvd, dvs, rem, quot;
   logic [CNT_W-1:0] cnt;

   logic             sgn_in, div0, ovf;
   logic [XLEN-1:0]  sh, diff;
   logic             cout, ge;

   assign sgn_in = ~op[0];
   assign div0   = (src2 == '0);
   assign ovf    = sgn_in && (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);

   // rem[31] set means the shifted value is >= 2^32, so it beats any divisor
   assign sh = {rem[XLEN-2:0], dvd[XLEN-1]};
   assign ge = rem[XLEN-1] | cout;

   comp u_comp (
      .data1 (sh),
      .data2 (dvs),
      .diff  (diff),
      .cout  (cout)
   );

   assign result = op_q[1] ? rem : quot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         quot      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (flush && state != S_IDLE) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && !flush) begin
                  op_q     <= op;
                  neg_q    <= sgn_in & (src1[XLEN-1] ^ src2[XLEN-1]);
                  neg_r    <= sgn_in & src1[XLEN-1];
                  dvd      <= (sgn_in && src1[XLEN-1]) ? neg32(src1) : src1;
                  dvs      <= (sgn_in && src2[XLEN-1]) ? neg32(src2) : src2;
                  rem      <= '0;
                  cnt      <= CNT_W'(XLEN);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (div0) begin
                     quot      <= '1;
                     rem       <= src1;
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end else if (ovf) begin
                     quot      <= 32'h8000_0000;
                     rem       <= '0;
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               rem <= ge ? diff : sh;
               dvd <= {dvd[XLEN-2:0], ge};
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= S_FIX;
            end
            S_FIX: begin
               quot      <= neg_q ? neg32(dvd) : dvd;
               rem       <= neg_r ? neg32(rem) : rem;
               state     <= S_DONE;
               out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, multi-cycle corner sequences
// and randomized ops against an arithmetic reference model.
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src1 = '0, src2 = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;

   int total = 0;
   int bad = 0;

   div_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
         return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      end
      return o[1] ? a % b : a / b;
   endfunction

   function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Called at posedge+1; returns result and edges from accept (inclusive) to out_valid.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      op = o; src1 = a; src2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[10];

   initial begin
      logic [31:0] res, a, b;
      logic [1:0]  o;
      int          lat, ov_cnt;

      vt[0] = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 34};
      vt[1] = '{OP_REMU, 32'd100, 32'd7, 32'd2, 34};
      vt[2] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
      vt[3] = '{OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
      vt[4] = '{OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1};
      vt[5] = '{OP_REMU, 32'd5, 32'd0, 32'd5, 1};
      vt[6] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vt[7] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};
      vt[8] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34};
      vt[9] = '{OP_DIVU, 32'd9, 32'd3, 32'd3, 34};

      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset result", result, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, res, lat);
         check($sformatf("vec%0d result", i), res, vt[i].exp);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      end

      // Hold result with out_ready low; a request while busy must be ignored
      op = OP_DIVU; src1 = 32'hFFFF_FFFF; src2 = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("busy after accept", 32'(busy), 32'd1);
      check("in_ready after accept", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      op = OP_DIVU; src1 = 32'd9; src2 = 32'd3; in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("hold first result", result, 32'hFFFF_FFFF);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold valid %0d", k), 32'(out_valid), 32'd1);
         check($sformatf("hold result %0d", k), result, 32'hFFFF_FFFF);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release out_valid", 32'(out_valid), 32'd0);
      check("release in_ready", 32'(in_ready), 32'd1);
      ov_cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) ov_cnt++;
      end
      check("ignored request produced no result", 32'(ov_cnt), 32'd0);

      // Flush during CALC
      op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush in_ready", 32'(in_ready), 32'd1);
      check("flush busy", 32'(busy), 32'd0);
      check("flush out_valid", 32'(out_valid), 32'd0);
      ov_cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) ov_cnt++;
      end
      check("flushed op produced no result", 32'(ov_cnt), 32'd0);

      // Flush in IDLE blocks the accept
      op = OP_DIVU; src1 = 32'd50; src2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("idle flush busy", 32'(busy), 32'd0);
      check("idle flush in_ready", 32'(in_ready), 32'd1);

      // Reset pulse mid-CALC
      op = OP_REMU; src1 = 32'hFFFF_FFFF; src2 = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset in_ready", 32'(in_ready), 32'd1);
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset result", result, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(OP_DIVU, 32'd9, 32'd3, res, lat);
      check("post-reset DIVU 9/3", res, 32'd3);

      // Randomized ops with corner-biased operands
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0:       a = 32'h8000_0000;
            1:       a = 32'($urandom_range(0, 100));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 9))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'd1;
            3:       b = 32'($urandom_range(1, 20));
            4:       b = 32'h8000_0000 | $urandom;
            default: b = $urandom;
         endcase
         run_op(o, a, b, res, lat);
         check($sformatf("rand%0d op%0d %h/%h result", i, o, a, b), res, model(o, a, b));
         check($sformatf("rand%0d latency", i), 32'(lat), 32'(model_lat(o, a, b)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
